// File: rtl/instr_stage_buffer.sv
// Circular fetch-to-decode instruction buffer with epoch-tagged entries.
// Entries whose epoch no longer matches the branch epoch are dropped at the head, and NOP is shown in their place.
module instr_stage_buffer #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                EPOCH_W   = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'hE320F000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          instr_in,
  input  logic [EPOCH_W-1:0]         epoch_in,
  input  logic [EPOCH_W-1:0]         epoch_ref,
  input  logic                       stall,
  input  logic                       flush,
  output logic [DATA_W-1:0]          instr_out,
  output logic [EPOCH_W-1:0]         epoch_out,
  output logic                       out_valid,
  output logic                       dropped,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0]  instr_mem_q [DEPTH];
  logic [EPOCH_W-1:0] epoch_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DATA_W-1:0]  head_instr;
  logic [EPOCH_W-1:0] head_epoch;
  logic empty, full, stale, push, pop;

  // Storage is deliberately left unreset; count gates every read of it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        instr_mem_q[gi] <= instr_in;
        epoch_mem_q[gi] <= epoch_in;
      end
    end
  end

  always_comb begin
    head_instr = instr_mem_q[rd_ptr_q];
    head_epoch = epoch_mem_q[rd_ptr_q];
    empty      = (count_q == '0);
    full       = (count_q == CNT_W'(DEPTH));
    stale      = !empty && (head_epoch != epoch_ref);
    out_valid  = !empty && !stale;
    dropped    = stale && !flush;
    instr_out  = out_valid ? head_instr : NOP_INSTR;
    epoch_out  = out_valid ? head_epoch : epoch_ref;
    // Ready depends only on occupancy and flush, never on stall or epoch_ref.
    in_ready   = !full && !flush;
    push       = in_valid && in_ready;
    pop        = (out_valid && !stall) || dropped;
    count      = count_q;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/instr_stage_buffer.md
Name: instr_stage_buffer

Overview:
- Parametrised successor to the single-entry fetch→decode instruction register.
- Provides a DEPTH-entry circular instruction buffer with valid/ready fill, stall-held drain and full flush.
- Each entry carries an epoch tag. An entry whose tag mismatches the current branch epoch is discarded automatically, and the decoder is fed NOP in its place.
- Sits between instruction fetch (producer) and the decoder (consumer).

Parameters:
- DATA_W, 32: instruction width.
- DEPTH, 4: number of entries; power of two, at least 2.
- EPOCH_W, 1: width of the branch epoch tag.
- NOP_INSTR, 32'hE320F000: value driven on instr_out when no valid instruction is presented; width DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  fetch presents instr_in/epoch_in.
- in_ready  out  1  buffer can accept an entry this cycle.
- instr_in  in  DATA_W  fetched instruction.
- epoch_in  in  EPOCH_W  epoch tag of the fetched instruction.
- epoch_ref  in  EPOCH_W  current architectural branch epoch.
- stall  in  1  decoder cannot consume this cycle.
- flush  in  1  discard all entries.
- instr_out  out  DATA_W  head instruction, or NOP_INSTR.
- epoch_out  out  EPOCH_W  head epoch tag, or epoch_ref when out_valid=0.
- out_valid  out  1  instr_out is a live instruction.
- dropped  out  1  a stale head entry is being discarded this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- State: storage array mem[DEPTH] of {epoch, instr}, rd_ptr and wr_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and count.
- Reset (rst=1 at a clk edge): rd_ptr=0, wr_ptr=0, count=0.
  - While count=0: in_ready=1 (if flush=0), out_valid=0, dropped=0, instr_out=NOP_INSTR.
  - Storage contents are not reset.
  - Reset takes priority over flush, push and pop.
- Derived combinational signals:
  - empty = (count==0); full = (count==DEPTH).
  - stale = !empty && (mem[rd_ptr].epoch != epoch_ref).
  - out_valid = !empty && !stale.
  - dropped = stale && !flush.
  - instr_out = out_valid ? mem[rd_ptr].instr : NOP_INSTR.
  - in_ready = !full && !flush. No combinational path from stall or epoch_ref to in_ready.
- Push: when in_valid && in_ready, write {epoch_in, instr_in} to mem[wr_ptr] and advance wr_ptr.
- Pop: occurs when (out_valid && !stall) || dropped; advance rd_ptr.
  - Stale entries are removed regardless of stall, at most one per cycle.
- Count update: count_next = count + push − pop. Simultaneous push and pop leaves count unchanged; both pointers advance.
- Latency: an entry pushed at edge N is visible on instr_out in the cycle after edge N. There is no bypass from instr_in to instr_out.
- Stall with out_valid=1: instr_out, epoch_out and rd_ptr hold. A push still fills a free slot.
- Flush: at the next edge rd_ptr=wr_ptr=0 and count=0.
  - A push in the flush cycle is refused (in_ready=0).
  - Flush beats pop and drop.
- Epoch change: when epoch_ref changes, every resident entry tagged with the old epoch drains via dropped, one per cycle.
  - Entries already tagged with the new epoch are delivered normally once they reach the head.
- Full: in_ready=0, even if a pop occurs in the same cycle. The freed slot becomes pushable in the next cycle.
- Empty: out_valid=0, dropped=0, instr_out=NOP_INSTR, and stall has no effect.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Order is strictly FIFO across the wrap.

Test Plan:
- Reset then fill: rst=1 for 2 cycles, then push 0xE0811002 and 0xE2433001 with epoch 0, epoch_ref=0, stall=0 → out_valid=0 and instr_out=0xE320F000 in cycle 0; 0xE0811002 appears the cycle after its push, then 0xE2433001; count returns to 0.
- Full and stall: stall=1, push 4 entries → count=4, in_ready=0, instr_out holds entry 0 across 5 cycles. Release stall → entries 0..3 appear in order, one per cycle, and in_ready returns high the cycle after the first pop.
- Wrap: push and pop 10 entries continuously with stall=0 and DEPTH=4 → output order 0..9 is preserved, count ≤ 2, no entry is lost or duplicated.
- Epoch discard: buffer holds entries A,B (epoch 0) and C (epoch 1); set epoch_ref=1 with stall=1 → dropped=1 for 2 consecutive cycles, instr_out=0xE320F000 during the drops, then C is presented with out_valid=1 and held while stall=1.
- Flush collision: with count=3, assert flush and in_valid together for one cycle → the next cycle has count=0, out_valid=0, and the pushed instruction never appears.
- Reset mid-operation: with count=2 and stall=1, assert rst=1 for one cycle → the next cycle has count=0, out_valid=0, in_ready=1, and stale storage never reaches instr_out.
